// File: rtl/coprocessor_memory_if.sv
// Host/coprocessor port bundle for coprocessor_memory.
// The master drives requests and the slave (the memory) returns block data and control cells.
interface coprocessor_memory_if #(
  parameter int log_size   = 10,
  parameter int cell_width = 32,
  parameter int blocks     = 4,
  parameter int width      = cell_width * blocks
);
  logic [log_size-1:0]   in_address;
  logic [width-1:0]      in_data;
  logic                  in_read_en;
  logic                  in_write_en;
  logic [cell_width-1:0] in_status;
  logic                  in_write_status_en;
  logic [width-1:0]      out_data;
  logic [cell_width-1:0] out_status;
  logic [cell_width-1:0] out_config;

  modport master (
    output in_address, in_data, in_read_en, in_write_en, in_status, in_write_status_en,
    input  out_data, out_status, out_config
  );

  modport slave (
    input  in_address, in_data, in_read_en, in_write_en, in_status, in_write_status_en,
    output out_data, out_status, out_config
  );
endinterface

// File: rtl/coprocessor_memory.sv
// Scratch memory moving `blocks` consecutive cells per access, with addresses wrapping modulo size.
// Cell 0 holds the host configuration word and cell 1 holds the coprocessor status word.
module coprocessor_memory #(
  parameter int size       = 1024,
  parameter int blocks     = 4,
  parameter int log_size   = 10,
  parameter int cell_width = 32,
  parameter int width      = cell_width * blocks
) (
  input logic                 in_clk,
  input logic                 in_reset,
  coprocessor_memory_if.slave bus
);

  localparam logic [log_size-1:0] config_idx = {log_size{1'b0}};
  localparam logic [log_size-1:0] status_idx = {{(log_size-1){1'b0}}, 1'b1};

  logic [cell_width-1:0] mem_r [size];
  logic [width-1:0]      out_data_r;

  // Lane addresses are truncated to log_size bits, which makes them wrap modulo size.
  function automatic logic [log_size-1:0] lane_addr(input logic [log_size-1:0] base,
                                                     input int lane);
    return base + log_size'(lane);
  endfunction

  // Cell array: block write first, then the status port overrides cell 1.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      mem_r <= '{default: '0};
    end else begin
      if (bus.in_write_en) begin
        for (int j = 0; j < blocks; j++) begin
          mem_r[lane_addr(bus.in_address, j)] <= bus.in_data[j*cell_width +: cell_width];
        end
      end
      if (bus.in_write_status_en) begin
        mem_r[status_idx] <= bus.in_status;
      end
    end
  end

  // Read register samples the pre-edge array contents, so a read that overlaps a write returns the old data.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      out_data_r <= '0;
    end else if (bus.in_read_en) begin
      for (int j = 0; j < blocks; j++) begin
        out_data_r[j*cell_width +: cell_width] <= mem_r[lane_addr(bus.in_address, j)];
      end
    end else begin
      out_data_r <= out_data_r;
    end
  end

  assign bus.out_data   = out_data_r;
  assign bus.out_config = mem_r[config_idx];
  assign bus.out_status = mem_r[status_idx];

endmodule

// File: tb/tb_coprocessor_memory.sv
// Scoreboard bench for coprocessor_memory: a shadow cell model feeds an expected-read queue,
// and each scenario task pops the queue and compares after the read edge.
module tb_coprocessor_memory;
  localparam int SIZE = 1024;
  localparam int BLOCKS = 4;
  localparam int LOG = 10;
  localparam int CW = 32;
  localparam int W = CW * BLOCKS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  coprocessor_memory_if #(.log_size(LOG), .cell_width(CW), .blocks(BLOCKS)) bus ();

  coprocessor_memory #(.size(SIZE), .blocks(BLOCKS), .log_size(LOG), .cell_width(CW)) dut (
    .in_clk  (clk),
    .in_reset(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] model [SIZE];
  logic [W-1:0]  exp_q [$];
  int n_checks = 0;
  int n_fail = 0;

  // One clock cycle of stimulus; the shadow model is read before it is written.
  task automatic drive(input logic [LOG-1:0] addr, input logic [W-1:0] data,
                       input logic rd, input logic wr,
                       input logic [CW-1:0] st, input logic st_en);
    logic [W-1:0] rv;
    logic [LOG-1:0] idx;
    @(negedge clk);
    bus.in_address = addr;
    bus.in_data = data;
    bus.in_read_en = rd;
    bus.in_write_en = wr;
    bus.in_status = st;
    bus.in_write_status_en = st_en;
    if (!rst) begin
      if (rd) begin
        for (int j = 0; j < BLOCKS; j++) begin
          idx = addr + LOG'(j);
          rv[j*CW +: CW] = model[idx];
        end
        exp_q.push_back(rv);
      end
      if (wr) begin
        for (int j = 0; j < BLOCKS; j++) begin
          idx = addr + LOG'(j);
          model[idx] = data[j*CW +: CW];
        end
      end
      if (st_en) model[1] = st;
    end
    @(posedge clk);
    #1;
    bus.in_read_en = 1'b0;
    bus.in_write_en = 1'b0;
    bus.in_write_status_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    drive(10'd0, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 1'b0, 1'b1, 32'h0, 1'b0);
    drive(10'd8, 128'h8D8D8D8D_8C8C8C8C_8B8B8B8B_8A8A8A8A, 1'b0, 1'b1, 32'h0, 1'b0);
    drive(10'd8, 128'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.out_data !== e) begin
      n_fail++;
      $display("FAIL reset_prefill_read: got %h expected %h", bus.out_data, e);
    end
    // Reset with every enable high: reset must override them all.
    rst = 1'b1;
    drive(10'd8, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    rst = 1'b0;
    model = '{default: '0};
    n_checks++;
    if (bus.out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
    end
    n_checks++;
    if (bus.out_config !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out_config: got %h expected 0", bus.out_config);
    end
    n_checks++;
    if (bus.out_status !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out_status: got %h expected 0", bus.out_status);
    end
    drive(10'd8, 128'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.out_data !== 128'h0 || bus.out_data !== e) begin
      n_fail++;
      $display("FAIL reset_read_addr8: got %h expected 0", bus.out_data);
    end
  endtask

  task automatic test_block_rw();
    logic [W-1:0] e;
    drive(10'd4, 128'h44444444_33333333_22222222_11111111, 1'b0, 1'b1, 32'h0, 1'b0);
    drive(10'd4, 128'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.out_data !== 128'h44444444_33333333_22222222_11111111 || bus.out_data !== e) begin
      n_fail++;
      $display("FAIL block_read_addr4: got %h expected %h", bus.out_data, e);
    end
    drive(10'd5, 128'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.out_data !== 128'h00000000_44444444_33333333_22222222 || bus.out_data !== e) begin
      n_fail++;
      $display("FAIL block_read_addr5: got %h expected %h", bus.out_data, e);
    end
    // No read enable: out_data must hold.
    drive(10'd4, 128'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (bus.out_data !== 128'h00000000_44444444_33333333_22222222) begin
      n_fail++;
      $display("FAIL block_hold: got %h expected 00000000444444443333333322222222", bus.out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic [W-1:0] e;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < BLOCKS; j++) d[j*CW +: CW] = 32'hB000_0000 | 32'(k << 8) | 32'(j);
      drive(LOG'(4 * k), d, 1'b0, 1'b1, 32'h0, 1'b0);
    end
    n_checks++;
    if (bus.out_config !== 32'hB000_0000) begin
      n_fail++;
      $display("FAIL sweep_config: got %h expected b0000000", bus.out_config);
    end
    n_checks++;
    if (bus.out_status !== 32'hB000_0001) begin
      n_fail++;
      $display("FAIL sweep_status: got %h expected b0000001", bus.out_status);
    end
    for (int k = 0; k < 10; k++) begin
      drive(LOG'(4 * k), 128'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.out_data !== e) begin
        n_fail++;
        $display("FAIL sweep_read_%0d: got %h expected %h", k, bus.out_data, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] e;
    drive(10'd1022, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0, 1'b1, 32'h0, 1'b0);
    n_checks++;
    if (bus.out_config !== 32'h0000_00A2) begin
      n_fail++;
      $display("FAIL wrap_config: got %h expected 000000a2", bus.out_config);
    end
    n_checks++;
    if (bus.out_status !== 32'h0000_00A3) begin
      n_fail++;
      $display("FAIL wrap_status: got %h expected 000000a3", bus.out_status);
    end
    drive(10'd1022, 128'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.out_data !== 128'h000000A3_000000A2_000000A1_000000A0 || bus.out_data !== e) begin
      n_fail++;
      $display("FAIL wrap_read_1022: got %h expected %h", bus.out_data, e);
    end
    drive(10'd1021, 128'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.out_data !== e) begin
      n_fail++;
      $display("FAIL wrap_read_1021: got %h expected %h", bus.out_data, e);
    end
  endtask

  task automatic test_status_priority();
    logic [W-1:0] e;
    drive(10'd0, 128'h00003333_00002222_00001111_0000CAFE, 1'b0, 1'b1, 32'h0000_BEEF, 1'b1);
    n_checks++;
    if (bus.out_status !== 32'h0000_BEEF) begin
      n_fail++;
      $display("FAIL prio_status: got %h expected 0000beef", bus.out_status);
    end
    n_checks++;
    if (bus.out_config !== 32'h0000_CAFE) begin
      n_fail++;
      $display("FAIL prio_config: got %h expected 0000cafe", bus.out_config);
    end
    drive(10'd0, 128'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.out_data !== 128'h00003333_00002222_0000BEEF_0000CAFE || bus.out_data !== e) begin
      n_fail++;
      $display("FAIL prio_read: got %h expected %h", bus.out_data, e);
    end
  endtask

  task automatic test_read_before_write();
    logic [W-1:0] e;
    drive(10'd8, 128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000, 1'b0, 1'b1, 32'h0, 1'b0);
    drive(10'd8, 128'h6B6B0003_6B6B0002_6B6B0001_6B6B0000, 1'b1, 1'b1, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.out_data !== 128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000 || bus.out_data !== e) begin
      n_fail++;
      $display("FAIL rbw_old_data: got %h expected %h", bus.out_data, e);
    end
    drive(10'd8, 128'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.out_data !== 128'h6B6B0003_6B6B0002_6B6B0001_6B6B0000 || bus.out_data !== e) begin
      n_fail++;
      $display("FAIL rbw_new_data: got %h expected %h", bus.out_data, e);
    end
  endtask

  initial begin
    bus.in_address = '0;
    bus.in_data = '0;
    bus.in_read_en = 1'b0;
    bus.in_write_en = 1'b0;
    bus.in_status = '0;
    bus.in_write_status_en = 1'b0;
    model = '{default: '0};
    rst = 1'b1;
    drive(10'd0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(10'd0, 128'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    test_reset();
    test_block_rw();
    test_back_to_back();
    test_wrap();
    test_status_priority();
    test_read_before_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/coprocessor_memory.md
# coprocessor_memory

Word-addressed scratch memory shared between the host interface and the coprocessor datapath. It stores `size` cells of `cell_width` bits and transfers `blocks` consecutive cells per access as one wide word. It also exposes two memory-mapped control cells: a configuration word written by the host and a status word the coprocessor can update through a dedicated port.

## Interface
- size, 1024: number of cells
- blocks, 4: cells per block access
- log_size, 10: address width; size = 2^log_size
- cell_width, 32: bits per cell
- width, cell_width*blocks: block data width (derived)

- in_clk  input  1  clock; all state changes on rising edge
- in_reset  input  1  synchronous, active-high reset
- in_address  input  log_size  base cell index of block access
- in_data  input  width  write block; lane j = bits [j*cell_width +: cell_width]
- in_read_en  input  1  block read request
- in_write_en  input  1  block write request
- in_status  input  cell_width  status value from coprocessor
- in_write_status_en  input  1  write in_status into status cell
- out_data  output  width  registered read block; lane j = cell[in_address+j]
- out_status  output  cell_width  live contents of cell 1
- out_config  output  cell_width  live contents of cell 0

## Operation
- Storage: array mem[0..size-1] of cell_width bits.
- Block mapping: lane j (0..blocks-1) ↔ mem[(in_address + j) mod size]; addresses wrap modulo size. No alignment requirement.
- Write (in_write_en=1): every lane of in_data stored to its mapped cell at the clock edge.
- Read (in_read_en=1): out_data ← mapped cells at the clock edge; out_data holds its value when in_read_en=0.
- Simultaneous read+write, same or overlapping cells: read returns pre-write contents (read-before-write).
- Status port (in_write_status_en=1): mem[1] ← in_status. If a block write also targets cell 1 in the same cycle, the status port wins; other lanes of the block write still complete.
- out_config = mem[0], out_status = mem[1]; combinational from the array, so they reflect writes from the cycle after the write edge.
- Reset (in_reset=1 at edge): all cells ← 0, out_data ← 0; it overrides every write/read enable in that cycle. Out_config/out_status therefore read 0 after reset.
- No error or busy signalling; every request completes in its cycle.

## Timing
- Write latency: data visible in the array (and out_config/out_status) after 1 edge.
- Read latency: 1 cycle; out_data valid after the edge at which in_read_en was sampled high.
- Back-to-back reads/writes every cycle are supported; no handshake.
- Reset mid-operation: the reset edge discards any pending write; out_data is 0 the following cycle.
- Address/enable changes between edges have no effect.

## Test plan
- Reset: fill cells, assert in_reset one cycle → out_data=0, out_config=0, out_status=0, a read of address 8 returns 0.
- Block write/read: write in_data=0x44444444_33333333_22222222_11111111 at address 4; read address 4 next cycle → out_data equals the same value, and a read of address 5 returns 0x00000000_44444444_33333333_22222222 assuming cell 8 was 0.
- Sweep: write ten blocks at addresses 0,4,…,36 with distinct data, then read each → each block matches; out_config = lane 0 of block 0, out_status = lane 1 of block 0.
- Wrap-around: write 0xA0,0xA1,0xA2,0xA3 at address 1022 → mem[1022]=0xA0, mem[1023]=0xA1, mem[0]=0xA2 (out_config=0xA2), mem[1]=0xA3 (out_status=0xA3).
- Status priority: same cycle block write to address 0 (lane1=0x1111) and in_write_status_en with in_status=0xBEEF → out_status=0xBEEF; lanes 0,2,3 written normally.
- Read-before-write: mem[8..11] hold X, read+write address 8 with Y same cycle → out_data=X; next read → Y.
